// File: rtl/cdb_pkg.sv
// Shared CDB types and default widths for the result arbiter.
// The fixed-width typedefs describe the default bus; cdb_arbiter_n builds its own parametrised copy.
package cdb_pkg;

  localparam int CDB_NUM_UNITS = 4;
  localparam int CDB_DATA_W    = 32;
  localparam int CDB_TAG_W     = 6;
  localparam int CDB_BUF_DEPTH = 2;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic                  valid;
    logic [CDB_DATA_W-1:0] data;
    logic                  branch;
    logic                  branch_taken;
  } cdb_bus;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  branch;
    logic                  branch_taken;
  } cdb_result_t;

  // Round-robin successor of channel g among n channels.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-channel result FIFO: wrap-around pointers plus occupancy count, ready from registered state only.
// Flush clears pointers/count and drops the same-cycle push and pop; storage is not reset.
module cdb_result_fifo #(
  parameter int BUF_DEPTH = 2,
  parameter int WIDTH     = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign push_ready = (count_q < CNT_FULL);
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];

  assign do_push = push_valid & push_ready & ~flush;
  assign do_pop  = pop & head_valid & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      // Push and pop in the same cycle leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter_n.sv
// Common-data-bus arbiter: per-unit result FIFOs, one registered CDB result per cycle.
// Define CDB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module cdb_arbiter_n
  import cdb_pkg::*;
#(
  parameter int NUM_UNITS = CDB_NUM_UNITS,
  parameter int DATA_W    = CDB_DATA_W,
  parameter int TAG_W     = CDB_TAG_W,
  parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_UNITS-1:0]        unit_valid,
  output logic [NUM_UNITS-1:0]        unit_ready,
  input  logic [NUM_UNITS*TAG_W-1:0]  unit_tag,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
  input  logic [NUM_UNITS-1:0]        unit_branch,
  input  logic [NUM_UNITS-1:0]        unit_branch_taken,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic                        cdb_branch,
  output logic                        cdb_branch_taken,
  output logic [NUM_UNITS-1:0]        cdb_grant
);

  localparam int IDX_W = $clog2(NUM_UNITS);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              branch;
    logic              branch_taken;
  } result_t;

  localparam int RES_W = $bits(result_t);

  result_t              push_res [NUM_UNITS];
  result_t              head_res [NUM_UNITS];
  logic [NUM_UNITS-1:0] head_valid;
  logic [NUM_UNITS-1:0] pop_vec;
  logic                 win_any;
  logic [IDX_W-1:0]     win_idx;

  result_t              cdb_res_q, cdb_res_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [NUM_UNITS-1:0] grant_q, grant_d;

`ifdef CDB_ARB_RR_EN
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_chan
      assign push_res[gi].tag          = unit_tag[gi*TAG_W +: TAG_W];
      assign push_res[gi].data         = unit_data[gi*DATA_W +: DATA_W];
      assign push_res[gi].branch       = unit_branch[gi];
      assign push_res[gi].branch_taken = unit_branch_taken[gi];

      assign pop_vec[gi] = win_any & ~flush & (win_idx == IDX_W'(gi));

      cdb_result_fifo #(
        .BUF_DEPTH (BUF_DEPTH),
        .WIDTH     (RES_W)
      ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (unit_valid[gi]),
        .push_ready (unit_ready[gi]),
        .push_data  (push_res[gi]),
        .pop        (pop_vec[gi]),
        .head_valid (head_valid[gi]),
        .head_data  (head_res[gi])
      );
    end
  endgenerate

  // Scan from lowest to highest search priority backwards so the last hit is the winner.
  always_comb begin
    win_any = |head_valid;
    win_idx = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
`ifdef CDB_ARB_RR_EN
      if (head_valid[(int'(rr_ptr_q) + k) % NUM_UNITS]) begin
        win_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_UNITS);
      end
`else
      if (head_valid[k]) begin
        win_idx = IDX_W'(k);
      end
`endif
    end
  end

  always_comb begin
    cdb_valid_d = 1'b0;
    grant_d     = '0;
    cdb_res_d   = '0;
    if (!flush && win_any) begin
      cdb_valid_d      = 1'b1;
      grant_d[win_idx] = 1'b1;
      cdb_res_d        = head_res[win_idx];
    end
  end

`ifdef CDB_ARB_RR_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!flush && win_any) begin
      rr_ptr_d = IDX_W'(rr_next(int'(win_idx), NUM_UNITS));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q <= 1'b0;
      grant_q     <= '0;
      cdb_res_q   <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      grant_q     <= grant_d;
      cdb_res_q   <= cdb_res_d;
    end
  end

  assign cdb_valid        = cdb_valid_q;
  assign cdb_grant        = grant_q;
  assign cdb_tag          = cdb_res_q.tag;
  assign cdb_data         = cdb_res_q.data;
  assign cdb_branch       = cdb_res_q.branch;
  assign cdb_branch_taken = cdb_res_q.branch_taken;

endmodule

// File: tb/tb_cdb_arbiter_n.sv
// Scoreboard bench for cdb_arbiter_n: a queue-based model predicts each cycle's CDB word,
// a negedge monitor pops and compares. Honours CDB_ARB_RR_EN like the design.
module tb_cdb_arbiter_n;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int TW    = 6;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    unit_valid = '0;
  logic [N-1:0]    unit_ready;
  logic [N*TW-1:0] unit_tag = '0;
  logic [N*DW-1:0] unit_data = '0;
  logic [N-1:0]    unit_branch = '0;
  logic [N-1:0]    unit_branch_taken = '0;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic            cdb_branch;
  logic            cdb_branch_taken;
  logic [N-1:0]    cdb_grant;

  cdb_arbiter_n #(
    .NUM_UNITS (N),
    .DATA_W    (DW),
    .TAG_W     (TW),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .unit_valid        (unit_valid),
    .unit_ready        (unit_ready),
    .unit_tag          (unit_tag),
    .unit_data         (unit_data),
    .unit_branch       (unit_branch),
    .unit_branch_taken (unit_branch_taken),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_data          (cdb_data),
    .cdb_branch        (cdb_branch),
    .cdb_branch_taken  (cdb_branch_taken),
    .cdb_grant         (cdb_grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          br;
    logic          tk;
  } res_t;

  typedef struct packed {
    logic         valid;
    logic [N-1:0] grant;
    res_t         r;
  } obs_t;

  res_t mq [N][$];
  obs_t exp_q [$];
  int   rr_m = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  int   tagc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    obs_t act;
    obs_t e;
    if (mon_en) begin
      act = {cdb_valid, cdb_grant, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL cdb_underflow: got v=%b tag=%h with no expectation at %0t", act.valid, act.r.tag, $time);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL cdb_word: got v=%b g=%b tag=%h data=%h br=%b tk=%b expected v=%b g=%b tag=%h data=%h br=%b tk=%b at %0t",
                   act.valid, act.grant, act.r.tag, act.r.data, act.r.br, act.r.tk,
                   e.valid, e.grant, e.r.tag, e.r.data, e.r.br, e.r.tk, $time);
        end else begin
          $display("cdb ok v=%b g=%b tag=%h data=%h at %0t", act.valid, act.grant, act.r.tag, act.r.data, $time);
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < N; i++) mq[i].delete();
  endtask

  // Model one rising edge from the current inputs, queue the expected CDB word, advance the clock.
  task automatic step();
    logic [N-1:0] mready;
    obs_t         e;
    int           w;
    int           u;
    res_t         r;
    for (int i = 0; i < N; i++) mready[i] = (mq[i].size() < DEPTH);
    chk("unit_ready", 64'(unit_ready), 64'(mready));
    e = '0;
    if (!rst) begin
      clear_model();
      rr_m = 0;
    end else if (flush) begin
      clear_model();
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        u = (rr_m + k) % N;
        if (w < 0 && mq[u].size() > 0) w = u;
      end
      if (w >= 0) begin
        r = mq[w].pop_front();
        e.valid    = 1'b1;
        e.grant[w] = 1'b1;
        e.r        = r;
`ifdef CDB_ARB_RR_EN
        rr_m = (w + 1) % N;
`endif
      end
      for (int i = 0; i < N; i++) begin
        if (unit_valid[i] && mready[i]) begin
          mq[i].push_back({unit_tag[i*TW +: TW], unit_data[i*DW +: DW], unit_branch[i], unit_branch_taken[i]});
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d, input logic br, input logic tk);
    unit_valid[i]          = 1'b1;
    unit_tag[i*TW +: TW]   = t;
    unit_data[i*DW +: DW]  = d;
    unit_branch[i]         = br;
    unit_branch_taken[i]   = tk;
  endtask

  task automatic idle();
    unit_valid = '0;
  endtask

  task automatic drive_all_counted();
    for (int i = 0; i < N; i++) begin
      drive(i, TW'(tagc), DW'(32'hB000 + tagc), 1'b0, 1'b0);
      tagc++;
    end
  endtask

  task automatic random_cycles(input int n, input int flush_pct);
    for (int c = 0; c < n; c++) begin
      unit_valid = N'($urandom);
      unit_tag   = (N*TW)'($urandom);
      for (int i = 0; i < N; i++) unit_data[i*DW +: DW] = $urandom;
      unit_branch       = N'($urandom);
      unit_branch_taken = N'($urandom);
      flush = ($urandom_range(0, 99) < flush_pct);
      step();
    end
    flush = 1'b0;
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("areset_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("areset_cdb_grant", 64'(cdb_grant), 64'd0);
    chk("areset_unit_ready", 64'(unit_ready), 64'hF);
    clear_model();
    rr_m  = 0;
    flush = 1'b0;
    idle();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset_cdb_grant", 64'(cdb_grant), 64'd0);
    chk("reset_unit_ready", 64'(unit_ready), 64'hF);
    mon_en = 1'b1;
    step();
    step();
    rst = 1'b1;

    // Single result on unit 2
    drive(2, 6'h05, 32'h1234, 1'b0, 1'b0);
    step();
    idle();
    step();
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_tag", 64'(cdb_tag), 64'h05);
    chk("single_data", 64'(cdb_data), 64'h1234);
    chk("single_grant", 64'(cdb_grant), 64'b0100);
    step();
    chk("single_done", 64'(cdb_valid), 64'd0);

    // All four units at once after reset: tags 1..4 in order in both arbitration modes
    do_reset();
    for (int i = 0; i < N; i++) drive(i, TW'(i + 1), DW'(32'hA0 + i), i[0], 1'b1);
    step();
    idle();
    for (int t = 1; t <= N; t++) begin
      step();
      chk("fair_tag", 64'(cdb_tag), 64'(t));
      chk("fair_grant", 64'(cdb_grant), 64'(1) << (t - 1));
    end

    // Refill unit 0 every cycle while the others hold one result each
    drive_all_counted();
    step();
    for (int c = 0; c < 10; c++) begin
      idle();
      drive(0, TW'(tagc), DW'(32'hC000 + tagc), 1'b1, 1'b0);
      tagc++;
      step();
    end
    idle();
    for (int c = 0; c < 8; c++) step();

    // Saturate all channels: back-pressure plus simultaneous push/pop on full FIFOs
    for (int c = 0; c < 10; c++) begin
      drive_all_counted();
      step();
    end
    idle();
    for (int c = 0; c < 12; c++) step();

    // Flush with a same-cycle push on unit 1
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 3; i++) drive(i, TW'(6'h30 + c * 3 + i), DW'(32'hF0 + i), 1'b0, 1'b0);
      step();
    end
    idle();
    flush = 1'b1;
    drive(1, 6'h3F, 32'hDEAD, 1'b1, 1'b1);
    step();
    flush = 1'b0;
    idle();
    chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("flush_unit_ready", 64'(unit_ready), 64'hF);
    for (int c = 0; c < 3; c++) step();

    // Randomized traffic with occasional flush
    random_cycles(400, 3);
    for (int c = 0; c < 10; c++) step();

    // Asynchronous reset in the middle of a burst
    random_cycles(12, 0);
    do_reset();
    random_cycles(100, 2);
    for (int c = 0; c < 12; c++) step();

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cdb_arbiter_n.md
# cdb_arbiter_n

Parametrised common-data-bus arbiter that buffers results from `NUM_UNITS` execution units and drives one result per cycle onto the CDB. It sits between the execution units (int, mem, mult, div, and future units) and every CDB consumer: dispatcher, issue queues and tag/register status. Per-unit result FIFOs with valid/ready back-pressure let units with different latencies complete in the same cycle without loss. Arbitration is round-robin, or fixed priority when so configured.

## Interface
Parameters:
- `NUM_UNITS`, 4: number of execution-unit result channels (2..8).
- `DATA_W`, 32: CDB data width.
- `TAG_W`, 6: rename tag width.
- `BUF_DEPTH`, 2: entries per channel FIFO, a power of two (1..8).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; discards all buffered and incoming results.
- `unit_valid` in NUM_UNITS: per-unit result valid.
- `unit_ready` out NUM_UNITS: per-unit FIFO not full.
- `unit_tag` in NUM_UNITS*TAG_W: packed result tags; unit i occupies slice [i*TAG_W +: TAG_W].
- `unit_data` in NUM_UNITS*DATA_W: packed result data.
- `unit_branch` in NUM_UNITS: the result is a branch resolution.
- `unit_branch_taken` in NUM_UNITS: branch outcome, 1 = taken.
- `cdb_valid` out 1: CDB carries a result this cycle.
- `cdb_tag` out TAG_W: CDB tag.
- `cdb_data` out DATA_W: CDB data.
- `cdb_branch` out 1: CDB branch flag.
- `cdb_branch_taken` out 1: CDB branch outcome.
- `cdb_grant` out NUM_UNITS: one-hot channel whose result is on the CDB; all zeros when `cdb_valid` = 0.

## Operation
- **Push.** Channel i accepts a result when `unit_valid[i] & unit_ready[i]` at a rising edge.
  - `unit_ready[i]` = (count_i < BUF_DEPTH).
  - Ready depends only on registered state. There is no combinational path from `unit_valid` or from the pop.
- **FIFO.** Each channel FIFO has a wrap-around read pointer and write pointer of log2(BUF_DEPTH) bits, plus a count of log2(BUF_DEPTH)+1 bits.
  - Simultaneous push and pop on the same channel leaves the count unchanged.
- **Arbitration.** Each cycle, one winner is chosen combinationally among non-empty FIFOs.
  - Round-robin: the search starts at `rr_ptr`. After a grant to channel g, `rr_ptr` becomes (g+1) mod NUM_UNITS.
  - No grant leaves `rr_ptr` unchanged.
  - The winner's head entry is popped and registered into the CDB output registers.
- **Output.**
  - `cdb_*` and `cdb_grant` are registered.
  - With no non-empty FIFO: `cdb_valid`, `cdb_grant`, `cdb_tag`, `cdb_data`, `cdb_branch` and `cdb_branch_taken` all load 0.
- **Flush.** At the edge where `flush` = 1:
  - All counts and pointers clear.
  - Same-cycle pushes are dropped.
  - No pop occurs.
  - The CDB registers load 0.
  - `rr_ptr` is unchanged.
- **Reset.** While `rst` = 0:
  - All counts, pointers, `rr_ptr` and CDB registers are 0.
  - `unit_ready` is all ones.
  - `cdb_valid` = 0 and `cdb_grant` = 0.
- FIFO data storage is not reset.

## Timing
- Latency is 1 cycle. A result pushed at edge k into an empty FIFO that wins arbitration appears on the CDB during cycle k+1 (valid after edge k+1).
- A result cannot be pushed and granted in the same cycle; there is no bypass.
- Sustained throughput is one CDB result per cycle. Each channel drains at most one result per cycle.
- With all channels continuously non-empty under round-robin, each channel is granted exactly once every NUM_UNITS cycles.
- A full FIFO popped at edge k raises `unit_ready` after edge k. The unit may push again at edge k+1.
- Reset deassertion mid-stream: the first push can occur at the first edge after `rst` returns to 1.

## Configuration
- Macro `CDB_ARB_RR_EN`.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, where the lowest index wins. `rr_ptr` is not implemented, and higher-index channels may starve while lower channels are full.
- Latency, flush and reset behaviour are identical in both builds.

## Structure
- Shared package `cdb_pkg` holds:
  - the `cdb_bus` typedef (tag, valid, data, branch, branch_taken);
  - the `cdb_result_t` typedef (tag, data, branch, branch_taken);
  - default-width localparams.
- One sub-module, `cdb_result_fifo`, parametrised by `BUF_DEPTH` and the payload width, is instantiated NUM_UNITS times in a generate loop.
- Arbitration and the output registers live in `cdb_arbiter_n`.

## Test plan
- **Single result.** Reset, then push tag 0x05 / data 0x1234 on unit 2 at edge 1 → at edge 2: `cdb_valid` = 1, tag 0x05, data 0x1234, `cdb_grant` = 4'b0100; at edge 3: `cdb_valid` = 0.
- **Round-robin fairness.** Push on all 4 units at edge 1 with tags 1..4 → CDB carries tags 1, 2, 3, 4 on edges 2..5 with one-hot grants. Under fixed priority the order is also 1..4. Refill unit 0 each cycle → round-robin still serves units 1..3 before unit 0 repeats.
- **Full / back-pressure.** BUF_DEPTH = 2. Hold unit 3 valid while units 0..2 saturate → `unit_ready[3]` = 0 after 2 accepted pushes. No result is lost and all tags appear exactly once, in FIFO order.
- **Simultaneous push and pop.** A full channel is granted at edge k while the unit pushes at edge k+1 → the count never exceeds BUF_DEPTH and the order is preserved.
- **Flush.** Fill 3 channels, assert `flush` with a same-cycle push on unit 1 → the next cycle has `cdb_valid` = 0, all `unit_ready` = 1, and the flushed tags never appear.
- **Asynchronous reset.** Drive `rst` = 0 mid-burst between clock edges → `cdb_valid` = 0 immediately, and no stale tag appears after release.
